// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: circular FIFO of {pc, inst} entries between fetch and decode.
// Push on in_valid & in_ready, pop on out_valid & out_ready. Reads are combinational
// from the head entry, so a pushed instruction is visible to decode one cycle later.
// Optional macro IFQ_BYPASS_EN: while the queue is empty, the offered instruction is
// presented to decode combinationally and, if consumed, passes through unstored.
module inst_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_pc,
  input  logic [31:0]            in_inst,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_inst,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          pass_through;

  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  assign head     = mem[rd_ptr];

  // Ready depends only on occupancy, so there is no combinational path from decode back to fetch.
  assign in_ready = !full;

`ifdef IFQ_BYPASS_EN
  // An empty queue hands a consumed instruction straight to decode instead of storing it.
  assign pass_through = empty & in_valid & out_ready & ~flush;
`else
  assign pass_through = 1'b0;
`endif

  assign push = in_valid & in_ready & ~pass_through;
  assign pop  = ~empty & out_ready;

  // Head presentation: the stored head entry, or the offered instruction when bypassing.
  always_comb begin
    // NOTE: every output gets a default first, so no path through this block infers a latch.
    out_valid = !empty;
    out_pc    = head.pc;
    out_inst  = head.inst;
`ifdef IFQ_BYPASS_EN
    if (empty) begin
      out_valid = in_valid & ~flush;
      out_pc    = in_pc;
      out_inst  = in_inst;
    end
`endif
  end

  // Entry storage written at the write pointer on every accepted push.
  always_ff @(posedge clock) begin
    // NOTE: storage is not reset; pointers and count alone decide which entries are live.
    if (push) begin
      mem[wr_ptr] <= '{pc: in_pc, inst: in_inst};
    end
  end

  // Pointers and occupancy; reset and flush both empty the queue and discard that cycle's push/pop.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every state update sees the pre-edge values.
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap from DEPTH-1 to 0 by natural overflow.
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue. A queue-based reference model tracks the
// live entries in program order; directed scenarios and a random run compare against it.
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } item_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_pc;
  logic [31:0]   in_inst;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_inst;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  item_t         mq[$];
  logic [CW-1:0] exp_count;
  logic          exp_in_ready;
  logic          exp_out_valid;
  logic [31:0]   exp_pc;
  logic [31:0]   exp_inst;

`ifdef IFQ_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  inst_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .count     (count)
  );

  always #5 clock = ~clock;

  // Expected outputs for the current inputs, from the model's contents.
  task automatic model_outputs();
    int n;
    n = mq.size();
    exp_count     = CW'(n);
    exp_in_ready  = (n != DEPTH);
    exp_out_valid = (n != 0);
    exp_pc        = 32'h0;
    exp_inst      = 32'h0;
    if (n != 0) begin
      exp_pc   = mq[0].pc;
      exp_inst = mq[0].inst;
    end else if (BYPASS) begin
      exp_out_valid = in_valid && !flush;
      exp_pc        = in_pc;
      exp_inst      = in_inst;
    end
  endtask

  // Advance one clock: decide transfers from pre-edge inputs, then update the model.
  task automatic tick();
    int    n;
    bit    do_pop;
    bit    do_push;
    item_t it;
    n       = mq.size();
    do_pop  = out_ready && (n != 0);
    do_push = in_valid && (n != DEPTH);
    if (BYPASS && n == 0 && out_ready) do_push = 1'b0;
    it.pc   = in_pc;
    it.inst = in_inst;
    @(posedge clock);
    if (reset || flush) begin
      mq.delete();
    end else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(it);
    end
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = 32'h0; in_inst = 32'h0;
  endtask

  // Empty the queue without checking (bounded).
  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    n_checks++; if (count !== CW'(0)) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_fill();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h8000_0000 + 32'(4 * i);
      in_inst  = $urandom;
      #1;
      if (i == 4) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_fifth_ready: got %b expected 0", in_ready); end
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    n_checks++; if (count !== CW'(4)) begin n_fail++; $display("FAIL fill_count: got %0d expected 4", count); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready: got %b expected 0", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      model_outputs();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fill_drain_valid[%0d]: got %b expected 1", i, out_valid); end
      n_checks++; if (out_pc !== 32'h8000_0000 + 32'(4 * i)) begin n_fail++; $display("FAIL fill_drain_pc[%0d]: got %h expected %h", i, out_pc, 32'h8000_0000 + 32'(4 * i)); end
      n_checks++; if (out_inst !== exp_inst) begin n_fail++; $display("FAIL fill_drain_inst[%0d]: got %h expected %h", i, out_inst, exp_inst); end
      tick();
    end
    out_ready = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fill_empty_valid: got %b expected 0", out_valid); end
    n_checks++; if (count !== CW'(0)) begin n_fail++; $display("FAIL fill_empty_count: got %0d expected 0", count); end
  endtask

  task automatic test_streaming();
    logic [31:0]   got[$];
    logic [CW-1:0] steady;
    idle_inputs();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_pc   = 32'h0000_1000 + 32'(4 * i);
      in_inst = $urandom;
      #1;
      steady = (BYPASS || i == 0) ? CW'(0) : CW'(1);
      n_checks++; if (count !== steady) begin n_fail++; $display("FAIL stream_count[%0d]: got %0d expected %0d", i, count, steady); end
      if (out_valid && out_ready) got.push_back(out_pc);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (out_valid && out_ready) got.push_back(out_pc);
      tick();
    end
    out_ready = 1'b0;
    n_checks++; if (got.size() != 20) begin n_fail++; $display("FAIL stream_delivered: got %0d expected 20", got.size()); end
    for (int i = 0; i < got.size() && i < 20; i++) begin
      n_checks++; if (got[i] !== 32'h0000_1000 + 32'(4 * i)) begin n_fail++; $display("FAIL stream_order[%0d]: got %h expected %h", i, got[i], 32'h0000_1000 + 32'(4 * i)); end
    end
  endtask

  task automatic test_wrap();
    idle_inputs();
    for (int idx = 0; idx < 10; idx++) begin
      in_valid  = 1'b1;
      out_ready = 1'b0;
      in_pc     = $urandom;
      in_inst   = 32'h0000_0013 + 32'(idx);
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid[%0d]: got %b expected 1", idx, out_valid); end
      n_checks++; if (out_inst !== 32'h0000_0013 + 32'(idx)) begin n_fail++; $display("FAIL wrap_inst[%0d]: got %h expected %h", idx, out_inst, 32'h0000_0013 + 32'(idx)); end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h8000_0000 + 32'(4 * i);
      in_inst  = $urandom;
      tick();
    end
    in_valid = 1'b0;
    #1;
    n_checks++; if (count !== CW'(3)) begin n_fail++; $display("FAIL flush_pre_count: got %0d expected 3", count); end
    flush     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_pc     = 32'h8000_0100;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    n_checks++; if (count !== CW'(0)) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
    in_valid = 1'b1;
    in_pc    = 32'h8000_0200;
    in_inst  = $urandom;
    tick();
    in_valid = 1'b0;
    #1;
    n_checks++; if (count !== CW'(1)) begin n_fail++; $display("FAIL flush_refill_count: got %0d expected 1", count); end
    n_checks++; if (out_pc !== 32'h8000_0200) begin n_fail++; $display("FAIL flush_refill_pc: got %h expected 80000200", out_pc); end
    drain();
  endtask

  task automatic test_full_simultaneous();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h0000_2000 + 32'(4 * i);
      in_inst  = $urandom;
      tick();
    end
    in_pc     = 32'h0000_3000;
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_sim_ready: got %b expected 0", in_ready); end
    n_checks++; if (out_pc !== 32'h0000_2000) begin n_fail++; $display("FAIL full_sim_head: got %h expected 00002000", out_pc); end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    n_checks++; if (count !== CW'(3)) begin n_fail++; $display("FAIL full_sim_count: got %0d expected 3", count); end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      #1;
      n_checks++; if (out_pc !== 32'h0000_2000 + 32'(4 * i)) begin n_fail++; $display("FAIL full_sim_drain[%0d]: got %h expected %h", i, out_pc, 32'h0000_2000 + 32'(4 * i)); end
      tick();
    end
    out_ready = 1'b0;
    #1;
    n_checks++; if (count !== CW'(0)) begin n_fail++; $display("FAIL full_sim_rejected_absent: got count %0d expected 0", count); end
  endtask

  task automatic test_reset_mid_stream();
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_pc    = $urandom;
      in_inst  = $urandom;
      tick();
    end
    #1;
    n_checks++; if (count !== CW'(2)) begin n_fail++; $display("FAIL rst_mid_pre_count: got %0d expected 2", count); end
    reset     = 1'b1;
    out_ready = 1'b1;
    tick();
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    n_checks++; if (count !== CW'(0)) begin n_fail++; $display("FAIL rst_mid_count: got %0d expected 0", count); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_random();
    idle_inputs();
    for (int cyc = 0; cyc < 400; cyc++) begin
      reset     = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_pc     = $urandom;
      in_inst   = $urandom;
      #1;
      model_outputs();
      n_checks++; if (count !== exp_count) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d expected %0d", cyc, count, exp_count); end
      n_checks++; if (in_ready !== exp_in_ready) begin n_fail++; $display("FAIL rand_in_ready[%0d]: got %b expected %b", cyc, in_ready, exp_in_ready); end
      n_checks++; if (out_valid !== exp_out_valid) begin n_fail++; $display("FAIL rand_out_valid[%0d]: got %b expected %b", cyc, out_valid, exp_out_valid); end
      if (exp_out_valid) begin
        n_checks++; if (out_pc !== exp_pc) begin n_fail++; $display("FAIL rand_out_pc[%0d]: got %h expected %h", cyc, out_pc, exp_pc); end
        n_checks++; if (out_inst !== exp_inst) begin n_fail++; $display("FAIL rand_out_inst[%0d]: got %h expected %h", cyc, out_inst, exp_inst); end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_streaming();
    test_wrap();
    test_flush();
    test_full_simultaneous();
    test_reset_mid_stream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
